// File: rtl/synth_audio_pkg.sv
// Shared audio definitions for the I2S transmit driver and receiver.
// Sample width follows AUDIO_24BIT_EN (24 bits when defined, else 16).
package synth_audio_pkg;

`ifdef AUDIO_24BIT_EN
    localparam int AUD_W = 24;
`else
    localparam int AUD_W = 16;
`endif

    localparam int SLOT_BITS_DEF = 32;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } aud_state_t;

endpackage

// File: rtl/audio_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input with rising-edge detect.
// o_rise is high for one clock per synchronized 0->1 transition.
module audio_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/audio_i2s_receiver.sv
// I2S receiver: oversampled BCK/LRCK/data, left+right pair with valid/ack.
// Sample width set by AUDIO_24BIT_EN via synth_audio_pkg.
module audio_i2s_receiver
    import synth_audio_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SLOT_BITS   = SLOT_BITS_DEF
) (
    input  logic             AUDIO_CLK,
    input  logic             iRST_N,
    input  logic             iAUD_BCK,
    input  logic             iAUD_LRCK,
    input  logic             iAUD_ADCDAT,
    output logic [AUD_W-1:0] o_lsound_in,
    output logic [AUD_W-1:0] o_rsound_in,
    output logic             o_valid,
    input  logic             i_ack,
    output logic             o_overrun
);

    localparam int              CW      = $clog2(SLOT_BITS + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(SLOT_BITS);
    localparam logic [AUD_W-1:0] MSB_BIT = {1'b1, {(AUD_W-1){1'b0}}};

    logic w_bck_rise, w_lrck, w_dat;
    logic w_bck_q_unused, w_lrck_rise_unused, w_dat_rise_unused;

    audio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bck (
        .i_clk(AUDIO_CLK), .i_rst_n(iRST_N), .i_d(iAUD_BCK),
        .o_q(w_bck_q_unused), .o_rise(w_bck_rise)
    );
    audio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lrck (
        .i_clk(AUDIO_CLK), .i_rst_n(iRST_N), .i_d(iAUD_LRCK),
        .o_q(w_lrck), .o_rise(w_lrck_rise_unused)
    );
    audio_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_dat (
        .i_clk(AUDIO_CLK), .i_rst_n(iRST_N), .i_d(iAUD_ADCDAT),
        .o_q(w_dat), .o_rise(w_dat_rise_unused)
    );

    aud_state_t       r_state, w_state_nxt;
    logic             r_lr_prev;
    logic [CW-1:0]    r_cnt;
    logic [AUD_W-1:0] r_shift, r_left;
    logic             r_have_left;
    logic [AUD_W-1:0] r_lsound, r_rsound;
    logic             r_valid, r_overrun;

    logic             w_change, w_commit_l, w_commit_r, w_load;
    logic [AUD_W-1:0] w_mask, w_word;

    assign w_change = w_bck_rise & (w_lrck != r_lr_prev);

    // Bit n of a slot lands at index AUD_W-n; beyond AUD_W the mask is zero,
    // so short slots come out left-aligned and zero-filled automatically.
    assign w_mask = MSB_BIT >> r_cnt;
    assign w_word = r_shift | (w_dat ? w_mask : '0);

    always_comb begin
        w_state_nxt = r_state;
        w_commit_l  = 1'b0;
        w_commit_r  = 1'b0;
        if (w_change) begin
            unique case (r_state)
                ST_SYNC:  w_state_nxt = w_lrck ? ST_RIGHT : ST_LEFT;
                ST_LEFT: begin
                    w_commit_l  = 1'b1;
                    w_state_nxt = ST_RIGHT;
                end
                ST_RIGHT: begin
                    w_commit_r  = 1'b1;
                    w_state_nxt = ST_LEFT;
                end
                default:  w_state_nxt = ST_SYNC;
            endcase
        end
    end

    assign w_load = w_commit_r & r_have_left;

    always_ff @(posedge AUDIO_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge AUDIO_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_lr_prev   <= 1'b0;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_left      <= '0;
            r_have_left <= 1'b0;
        end else if (w_bck_rise) begin
            r_lr_prev <= w_lrck;
            if (w_change) begin
                r_shift <= '0;
                r_cnt   <= '0;
            end else begin
                r_shift <= w_word;
                if (r_cnt != CNT_MAX) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_commit_l) begin
                r_left      <= w_word;
                r_have_left <= 1'b1;
            end else if (w_change) begin
                r_have_left <= 1'b0;
            end
        end
    end

    always_ff @(posedge AUDIO_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_lsound  <= '0;
            r_rsound  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_load) begin
                r_lsound  <= r_left;
                r_rsound  <= w_word;
                r_valid   <= 1'b1;
                r_overrun <= r_valid & ~i_ack;
            end else if (r_valid && i_ack) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_lsound_in = r_lsound;
    assign o_rsound_in = r_rsound;
    assign o_valid     = r_valid;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_audio_i2s_receiver.sv
// Directed bench for audio_i2s_receiver: frames, overrun, ack timing, reset.
// Expected words follow the AUDIO_24BIT_EN build selection.
module tb_audio_i2s_receiver;
    import synth_audio_pkg::*;

`ifdef AUDIO_24BIT_EN
    localparam logic [31:0] E1L = 32'h123456, E1R = 32'hABCDEF;
    localparam logic [31:0] E2L = 32'h8001FF, E2R = 32'h7FFEFF;
    localparam logic [31:0] E3L = 32'hA5A500, E3R = 32'h5A5A00;
    localparam logic [31:0] E5L = 32'h0F1E2D, E5R = 32'hC3B2A1;
`else
    localparam logic [31:0] E1L = 32'h1234, E1R = 32'hABCD;
    localparam logic [31:0] E2L = 32'h8001, E2R = 32'h7FFE;
    localparam logic [31:0] E3L = 32'hA5A5, E3R = 32'h5A5A;
    localparam logic [31:0] E5L = 32'h0F1E, E5R = 32'hC3B2;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             bck = 1'b0;
    logic             lrck = 1'b0;
    logic             dat = 1'b0;
    logic             ack = 1'b0;
    logic [AUD_W-1:0] lsnd, rsnd;
    logic             vld, ovr;

    int n_run = 0;
    int n_fail = 0;
    int ov_cnt = 0;
    int ov_base;
    logic pend = 1'b0;
    logic skip = 1'b0;

    always #5 clk = ~clk;

    audio_i2s_receiver dut (
        .AUDIO_CLK  (clk),
        .iRST_N     (rst_n),
        .iAUD_BCK   (bck),
        .iAUD_LRCK  (lrck),
        .iAUD_ADCDAT(dat),
        .o_lsound_in(lsnd),
        .o_rsound_in(rsnd),
        .o_valid    (vld),
        .i_ack      (ack),
        .o_overrun  (ovr)
    );

    always @(negedge clk) begin
        if (ovr) ov_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One BCK period: low 4 clocks, high 4 clocks; ack_k=3 drives i_ack
    // during the clock that ends in the bit-event register update.
    task automatic send_bit(input logic lr, input logic d, input int ack_k);
        lrck = lr;
        dat  = d;
        bck  = 1'b0;
        repeat (4) @(negedge clk);
        bck = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            ack = (k == ack_k);
            @(negedge clk);
        end
        ack = 1'b0;
    endtask

    task automatic send_slot(input logic lr, input int n, input logic [31:0] w);
        if (!skip) send_bit(lr, pend, 0);
        skip = 1'b0;
        for (int i = 0; i < n - 1; i++) send_bit(lr, w[31-i], 0);
        pend = w[32-n];
    endtask

    task automatic close_frame(input int ack_k);
        send_bit(1'b0, pend, ack_k);
        skip = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_l", 32'(lsnd), 32'h0);
        chk("rst_r", 32'(rsnd), 32'h0);
        chk("rst_v", 32'(vld), 32'h0);
        chk("rst_o", 32'(ovr), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send_slot(1'b1, 4, 32'h0);
        send_slot(1'b0, 32, 32'h12345600);
        send_slot(1'b1, 32, 32'hABCDEF00);
        chk("f1_v_pre", 32'(vld), 32'h0);
        close_frame(0);
        chk("f1_v", 32'(vld), 32'h1);
        chk("f1_l", 32'(lsnd), E1L);
        chk("f1_r", 32'(rsnd), E1R);

        ov_base = ov_cnt;
        send_slot(1'b0, 32, 32'h8001FFFF);
        send_slot(1'b1, 32, 32'h7FFEFFFF);
        chk("f2_hold_l", 32'(lsnd), E1L);
        close_frame(0);
        chk("f2_v", 32'(vld), 32'h1);
        chk("f2_l", 32'(lsnd), E2L);
        chk("f2_r", 32'(rsnd), E2R);
        chk("f2_ovr", 32'(ov_cnt - ov_base), 32'd1);

        ov_base = ov_cnt;
        send_slot(1'b0, 16, 32'hA5A50000);
        send_slot(1'b1, 16, 32'h5A5A0000);
        close_frame(3);
        chk("f3_v", 32'(vld), 32'h1);
        chk("f3_l", 32'(lsnd), E3L);
        chk("f3_r", 32'(rsnd), E3R);
        chk("f3_ovr", 32'(ov_cnt - ov_base), 32'd0);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
        chk("ack_clr", 32'(vld), 32'h0);
        chk("ack_hold_l", 32'(lsnd), E3L);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("ack_idle", 32'(vld), 32'h0);

        send_slot(1'b0, 32, 32'h11111111);
        send_slot(1'b1, 8, 32'hF0F00000);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_l", 32'(lsnd), 32'h0);
        chk("mrst_r", 32'(rsnd), 32'h0);
        chk("mrst_v", 32'(vld), 32'h0);
        chk("mrst_o", 32'(ovr), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        skip = 1'b1;
        send_slot(1'b1, 8, 32'hFF000000);
        send_slot(1'b0, 32, 32'h0F1E2D3C);
        chk("part_v", 32'(vld), 32'h0);
        send_slot(1'b1, 32, 32'hC3B2A190);
        chk("f5_v_pre", 32'(vld), 32'h0);
        close_frame(0);
        chk("f5_v", 32'(vld), 32'h1);
        chk("f5_l", 32'(lsnd), E5L);
        chk("f5_r", 32'(rsnd), E5R);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
